// File: rtl/keccak_io_buffer.sv
// keccak_io_buffer: core-side endpoint of the 64-bit keccak streaming protocol.
// It collects one rate block of words from the accelerator FSM, hands the whole
// block to the permutation core, captures the core's rate output and, once
// last_block is requested, streams the digest words back out.
//
// Optional build macro: KECCAK_IO_PAD_EN
//   When defined, a last_block seen in FILL pads the partial block in hardware
//   (0x06 after the last word, 0x80.. in the top byte of the last lane) and
//   the padded block goes straight to squeeze after its permutation.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         pulse, begins a new message (core_init pulses)
//   din/din_valid input word stream
//   last_block    level, requests squeeze
//   buffer_full   block complete or being permuted
//   ready         block accepts a word, last_block or start
//   dout/dout_valid digest word stream
//   core_init     pulse, core clears its state
//   perm_start    pulse, core absorbs blk_o and permutes
//   blk_o         assembled block, word k at [64k+63:64k]
//   perm_done     pulse, permutation finished
//   rate_i        core rate lanes 0..OUT_WORDS-1, valid with perm_done
module keccak_io_buffer #(
   parameter int unsigned RATE_WORDS = 21,
   parameter int unsigned OUT_WORDS  = 4,
   parameter int unsigned LANE_W     = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [LANE_W-1:0]            din,
   input  logic                         din_valid,
   output logic                         buffer_full,
   input  logic                         last_block,
   output logic                         ready,
   output logic [LANE_W-1:0]            dout,
   output logic                         dout_valid,
   output logic                         core_init,
   output logic                         perm_start,
   output logic [RATE_WORDS*LANE_W-1:0] blk_o,
   input  logic                         perm_done,
   input  logic [OUT_WORDS*LANE_W-1:0]  rate_i
);

   localparam int unsigned CNT_W = $clog2(RATE_WORDS + 1);
   localparam int unsigned BLK_W = RATE_WORDS * LANE_W;
   localparam int unsigned OUT_W = OUT_WORDS * LANE_W;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_WORDS - 1);
   localparam logic [CNT_W-1:0] OUT_CNT  = CNT_W'(OUT_WORDS);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FILL      = 3'd1,
      PERM      = 3'd2,
      WAIT_LAST = 3'd3,
      SQUEEZE   = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BLK_W-1:0]   blk_q, blk_d;
   logic [OUT_W-1:0]   sq_q, sq_d;
   logic [LANE_W-1:0]  dout_q, dout_d;
   logic               dout_valid_q, dout_valid_d;
   logic               buffer_full_q, buffer_full_d;
   logic               ready_q, ready_d;
   logic               perm_start_q, perm_start_d;
   logic               core_init_q, core_init_d;
`ifdef KECCAK_IO_PAD_EN
   logic               pad_q, pad_d;
   logic [CNT_W-1:0]   fill_n;
`endif

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         blk_q         <= '0;
         sq_q          <= '0;
         dout_q        <= '0;
         dout_valid_q  <= 1'b0;
         buffer_full_q <= 1'b0;
         ready_q       <= 1'b1;
         perm_start_q  <= 1'b0;
         core_init_q   <= 1'b0;
`ifdef KECCAK_IO_PAD_EN
         pad_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         blk_q         <= blk_d;
         sq_q          <= sq_d;
         dout_q        <= dout_d;
         dout_valid_q  <= dout_valid_d;
         buffer_full_q <= buffer_full_d;
         ready_q       <= ready_d;
         perm_start_q  <= perm_start_d;
         core_init_q   <= core_init_d;
`ifdef KECCAK_IO_PAD_EN
         pad_q         <= pad_d;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      blk_d         = blk_q;
      sq_d          = sq_q;
      dout_d        = dout_q;
      dout_valid_d  = 1'b0;
      buffer_full_d = buffer_full_q;
      ready_d       = ready_q;
      perm_start_d  = 1'b0;
      core_init_d   = 1'b0;
`ifdef KECCAK_IO_PAD_EN
      pad_d         = pad_q;
      fill_n        = '0;
`endif

      // start restarts the message from any state that is not busy
      if (start && (state_q == IDLE || state_q == FILL || state_q == WAIT_LAST)) begin
         state_d       = FILL;
         cnt_d         = '0;
         blk_d         = '0;
         core_init_d   = 1'b1;
         ready_d       = 1'b1;
         buffer_full_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_d = 1'b1;
            end

            FILL: begin
`ifdef KECCAK_IO_PAD_EN
               if (last_block) begin
                  fill_n = cnt_q;
                  if (din_valid) begin
                     blk_d[LANE_W*int'(cnt_q) +: LANE_W] = din;
                     fill_n = CNT_W'(cnt_q + 1'b1);
                  end
                  cnt_d         = '0;
                  state_d       = PERM;
                  buffer_full_d = 1'b1;
                  ready_d       = 1'b0;
                  perm_start_d  = 1'b1;
                  // A full block cannot be padded; last_block stays pending for WAIT_LAST
                  if (fill_n != CNT_W'(RATE_WORDS)) begin
                     blk_d[LANE_W*int'(fill_n) +: LANE_W] =
                        blk_d[LANE_W*int'(fill_n) +: LANE_W] ^ LANE_W'(64'h06);
                     blk_d[LANE_W*(RATE_WORDS-1) +: LANE_W] =
                        blk_d[LANE_W*(RATE_WORDS-1) +: LANE_W] ^ LANE_W'(64'h8000_0000_0000_0000);
                     pad_d = 1'b1;
                  end
               end else
`endif
               if (din_valid) begin
                  blk_d[LANE_W*int'(cnt_q) +: LANE_W] = din;
                  if (cnt_q == LAST_IDX) begin
                     cnt_d         = '0;
                     state_d       = PERM;
                     buffer_full_d = 1'b1;
                     ready_d       = 1'b0;
                     perm_start_d  = 1'b1;
                  end else begin
                     cnt_d = CNT_W'(cnt_q + 1'b1);
                  end
               end
            end

            PERM: begin
               if (perm_done) begin
                  sq_d          = rate_i;
                  blk_d         = '0;
                  buffer_full_d = 1'b0;
`ifdef KECCAK_IO_PAD_EN
                  if (pad_q) begin
                     pad_d        = 1'b0;
                     state_d      = SQUEEZE;
                     ready_d      = 1'b0;
                     dout_d       = rate_i[0 +: LANE_W];
                     dout_valid_d = 1'b1;
                     cnt_d        = CNT_W'(1);
                  end else
`endif
                  begin
                     state_d = WAIT_LAST;
                     ready_d = 1'b1;
                  end
               end
            end

            WAIT_LAST: begin
               // Word 0 leaves on the transition so the digest has no leading bubble
               if (last_block) begin
                  state_d      = SQUEEZE;
                  ready_d      = 1'b0;
                  dout_d       = sq_q[0 +: LANE_W];
                  dout_valid_d = 1'b1;
                  cnt_d        = CNT_W'(1);
               end else if (din_valid) begin
                  blk_d[0 +: LANE_W] = din;
                  cnt_d              = CNT_W'(1);
                  state_d            = FILL;
               end
            end

            SQUEEZE: begin
               if (cnt_q == OUT_CNT) begin
                  state_d = IDLE;
                  ready_d = 1'b1;
                  cnt_d   = '0;
               end else begin
                  dout_d       = sq_q[LANE_W*int'(cnt_q) +: LANE_W];
                  dout_valid_d = 1'b1;
                  cnt_d        = CNT_W'(cnt_q + 1'b1);
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign buffer_full = buffer_full_q;
   assign ready       = ready_q;
   assign dout        = dout_q;
   assign dout_valid  = dout_valid_q;
   assign core_init   = core_init_q;
   assign perm_start  = perm_start_q;
   assign blk_o       = blk_q;

endmodule

// File: tb/tb_keccak_io_buffer.sv
// Directed bench for keccak_io_buffer: block fill, permutation handshake,
// squeeze streaming, chained blocks, restart, reset abort and (when built with
// KECCAK_IO_PAD_EN) hardware padding.
module tb_keccak_io_buffer;

   localparam int unsigned RW = 21;
   localparam int unsigned OW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [63:0]     din;
   logic            din_valid;
   logic            buffer_full;
   logic            last_block;
   logic            ready;
   logic [63:0]     dout;
   logic            dout_valid;
   logic            core_init;
   logic            perm_start;
   logic [RW*64-1:0] blk_o;
   logic            perm_done;
   logic [OW*64-1:0] rate_i;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   keccak_io_buffer #(.RATE_WORDS(RW), .OUT_WORDS(OW), .LANE_W(64)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .din        (din),
      .din_valid  (din_valid),
      .buffer_full(buffer_full),
      .last_block (last_block),
      .ready      (ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .core_init  (core_init),
      .perm_start (perm_start),
      .blk_o      (blk_o),
      .perm_done  (perm_done),
      .rate_i     (rate_i)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] bw(input int k);
      return blk_o[k*64 +: 64];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; din = '0; din_valid = 1'b0;
      last_block = 1'b0; perm_done = 1'b0; rate_i = '0;
      repeat (3) tick();
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_full", 64'(buffer_full), 64'd0);
      check("rst_dv", 64'(dout_valid), 64'd0);
      check("rst_dout", dout, 64'd0);
      check("rst_ps", 64'(perm_start), 64'd0);
      check("rst_ci", 64'(core_init), 64'd0);
      check("rst_blk", 64'(|blk_o), 64'd0);
      rst_n = 1'b1;
      tick();

      // IDLE ignores data and last_block
      din = 64'd55; din_valid = 1'b1; last_block = 1'b1;
      tick();
      din_valid = 1'b0; last_block = 1'b0;
      check("idle_blk", bw(0), 64'd0);
      check("idle_dv", 64'(dout_valid), 64'd0);
      check("idle_ready", 64'(ready), 64'd1);

      // Block A: 21 words k+1
      start = 1'b1; tick(); start = 1'b0;
      check("a_ci", 64'(core_init), 64'd1);
      for (int k = 0; k < RW; k++) begin
         din = 64'(k + 1); din_valid = 1'b1;
`ifndef KECCAK_IO_PAD_EN
         last_block = (k == 5);
`endif
         tick();
         if (k == 0) check("a_ci_pulse", 64'(core_init), 64'd0);
         if (k == RW - 2) begin
            check("a_ps_early", 64'(perm_start), 64'd0);
            check("a_full_early", 64'(buffer_full), 64'd0);
         end
      end
      last_block = 1'b0;
      check("a_ps", 64'(perm_start), 64'd1);
      check("a_full", 64'(buffer_full), 64'd1);
      check("a_ready", 64'(ready), 64'd0);
      check("a_w0", bw(0), 64'd1);
      check("a_w10", bw(10), 64'd11);
      check("a_w20", bw(20), 64'd21);

      // PERM ignores din_valid, start and last_block
      din = 64'hDEAD; din_valid = 1'b1;
      tick();
      check("perm_ps_pulse", 64'(perm_start), 64'd0);
      start = 1'b1; last_block = 1'b1;
      repeat (21) tick();
      check("perm_w3", bw(3), 64'd4);
      check("perm_w0", bw(0), 64'd1);
      check("perm_full", 64'(buffer_full), 64'd1);
      check("perm_ci", 64'(core_init), 64'd0);
      din_valid = 1'b0; start = 1'b0; last_block = 1'b0;
      tick();
      perm_done = 1'b1; rate_i = {64'd4, 64'd3, 64'd2, 64'd1};
      tick();
      perm_done = 1'b0; rate_i = '0;
      check("pd_full", 64'(buffer_full), 64'd0);
      check("pd_ready", 64'(ready), 64'd1);
      check("pd_blk_clr", 64'(|blk_o), 64'd0);

      // Squeeze 1,2,3,4
      last_block = 1'b1; tick(); last_block = 1'b0;
      check("sq_dv0", 64'(dout_valid), 64'd1);
      check("sq_d0", dout, 64'd1);
      check("sq_ready", 64'(ready), 64'd0);
      for (int j = 1; j < OW; j++) begin
         tick();
         check("sq_dv", 64'(dout_valid), 64'd1);
         check("sq_d", dout, 64'(j + 1));
      end
      perm_done = 1'b1;
      tick();
      perm_done = 1'b0;
      check("sq_end_dv", 64'(dout_valid), 64'd0);
      check("sq_end_ready", 64'(ready), 64'd1);
      check("sq_hold", dout, 64'd4);
      tick();
      check("stray_pd_full", 64'(buffer_full), 64'd0);
      check("stray_pd_ready", 64'(ready), 64'd1);

      // Block B then chained block C through WAIT_LAST
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < RW; k++) begin
         din = 64'(k + 101); din_valid = 1'b1; tick();
      end
      din_valid = 1'b0;
      check("b_ps", 64'(perm_start), 64'd1);
      tick();
      perm_done = 1'b1; rate_i = {64'hD, 64'hC, 64'hB, 64'hA};
      tick();
      perm_done = 1'b0; rate_i = '0;
      for (int k = 0; k < 7; k++) begin
         din = 64'(k + 200); din_valid = 1'b1; tick();
         if (k == 0) begin
            check("c_w0", bw(0), 64'd200);
            check("c_w1_clr", bw(1), 64'd0);
            check("c_ready", 64'(ready), 64'd1);
         end
      end
      check("c_w6", bw(6), 64'd206);
      check("c_w7_clr", bw(7), 64'd0);

      // Restart after 7 words; start beats din_valid
      start = 1'b1; din = 64'hBAD; din_valid = 1'b1; tick();
      start = 1'b0; din_valid = 1'b0;
      check("r_ci", 64'(core_init), 64'd1);
      check("r_blk_clr", 64'(|blk_o), 64'd0);
      for (int k = 0; k < RW; k++) begin
         din = 64'(k + 300); din_valid = 1'b1; tick();
         if (k == RW - 2) check("r_ps_early", 64'(perm_start), 64'd0);
      end
      din_valid = 1'b0;
      check("r_ps", 64'(perm_start), 64'd1);
      check("r_w0", bw(0), 64'd300);
      check("r_w7", bw(7), 64'd307);
      check("r_w20", bw(20), 64'd320);
      tick();
      perm_done = 1'b1; rate_i = {64'h14, 64'h13, 64'h12, 64'h11};
      tick();
      perm_done = 1'b0; rate_i = '0;
      last_block = 1'b1; tick(); last_block = 1'b0;
      for (int j = 0; j < OW; j++) begin
         if (j > 0) tick();
         check("r_sq_dv", 64'(dout_valid), 64'd1);
         check("r_sq_d", dout, 64'(j + 'h11));
      end
      tick();
      check("r_sq_end", 64'(dout_valid), 64'd0);

`ifdef KECCAK_IO_PAD_EN
      // Hardware padding: 3 words then last_block
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         din = 64'(k + 1); din_valid = 1'b1; tick();
      end
      din_valid = 1'b0;
      last_block = 1'b1; tick(); last_block = 1'b0;
      check("pad_ps", 64'(perm_start), 64'd1);
      check("pad_w2", bw(2), 64'd3);
      check("pad_w3", bw(3), 64'h06);
      check("pad_w20", bw(20), 64'h8000_0000_0000_0000);
      tick();
      perm_done = 1'b1; rate_i = {64'd4, 64'd3, 64'd2, 64'd1};
      tick();
      perm_done = 1'b0; rate_i = '0;
      for (int j = 0; j < OW; j++) begin
         if (j > 0) tick();
         check("pad_sq_dv", 64'(dout_valid), 64'd1);
         check("pad_sq_d", dout, 64'(j + 1));
      end
      tick();
      check("pad_end_dv", 64'(dout_valid), 64'd0);
      check("pad_end_ready", 64'(ready), 64'd1);
`endif

      // Asynchronous reset mid-fill
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         din = 64'(k + 7); din_valid = 1'b1; tick();
      end
      #2 rst_n = 1'b0;
      #1;
      check("arst_blk", 64'(|blk_o), 64'd0);
      check("arst_ready", 64'(ready), 64'd1);
      check("arst_full", 64'(buffer_full), 64'd0);
      tick();
      din_valid = 1'b0; rst_n = 1'b1;
      tick();
      check("arst_ps", 64'(perm_start), 64'd0);
      check("arst_ci", 64'(core_init), 64'd0);
      check("arst_after_blk", bw(0), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/keccak_io_buffer.md
Name: keccak_io_buffer

Overview:
- Core-side endpoint of the 64-bit keccak streaming protocol (start / din / din_valid / buffer_full / last_block / ready / dout / dout_valid) driven by the accelerator FSM.
- Collects one rate block of 64-bit words, hands it in parallel to the permutation core, and captures the core's rate output.
- On last_block, streams the digest words back out with dout_valid.
- Sits inside the keccak wrapper, between the accelerator FSM and the permutation datapath.

Parameters:
- RATE_WORDS, 21, 64-bit words per rate block (1344 bits).
- OUT_WORDS, 4, digest words streamed on squeeze (256 bits); legal range 1..RATE_WORDS.
- LANE_W, 64, lane / word width; fixed at 64.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a new message.
- din  in  64  input word.
- din_valid  in  1  din is valid this cycle.
- buffer_full  out  1  block complete or being permuted; no words accepted.
- last_block  in  1  level; requests squeeze.
- ready  out  1  block accepts a new word, last_block or start.
- dout  out  64  digest word.
- dout_valid  out  1  dout is valid this cycle.
- core_init  out  1  pulse; core clears its 1600-bit state.
- perm_start  out  1  pulse; core absorbs blk_o and permutes.
- blk_o  out  RATE_WORDS*64  assembled block; word k at bits [64k+63:64k].
- perm_done  in  1  pulse; permutation finished.
- rate_i  in  OUT_WORDS*64  core rate lanes 0..OUT_WORDS-1, valid while perm_done=1.

Behaviour:
- Clock and reset: single clock domain, rising edge. rst_n is asynchronous, active low.
- Reset values:
  - state = IDLE.
  - word counter = 0; blk_o = 0; squeeze register = 0.
  - dout = 0, dout_valid = 0, buffer_full = 0, perm_start = 0, core_init = 0.
  - ready = 1.
- All outputs are registered.
- Reset asserted mid-operation aborts at once; no pulse is emitted afterwards.
- States: IDLE, FILL, PERM, WAIT_LAST, SQUEEZE.
- IDLE:
  - ready = 1.
  - start -> FILL; core_init pulses 1 cycle; counter = 0; blk_o cleared.
  - din_valid and last_block are ignored.
- FILL:
  - ready = 1.
  - Each din_valid cycle writes din into word[counter] and increments counter.
  - When the RATE_WORDS-th word is accepted, the next cycle shows buffer_full = 1, ready = 0, perm_start = 1 (1 cycle), and state -> PERM. Counter wraps to 0.
  - start in FILL restarts: counter = 0, blk_o cleared, core_init pulses. start has priority over din_valid in the same cycle.
- PERM:
  - buffer_full = 1, ready = 0.
  - din_valid, start and last_block are ignored.
  - On perm_done: capture rate_i into the squeeze register, clear blk_o, state -> WAIT_LAST. The next cycle shows buffer_full = 0, ready = 1.
  - A perm_done outside PERM is ignored.
- WAIT_LAST (priority order):
  - start -> same as start in FILL.
  - else last_block -> SQUEEZE, ready = 0.
  - else din_valid -> store word 0, counter = 1, state -> FILL (next block; chaining state is held by the core).
- SQUEEZE:
  - For OUT_WORDS consecutive cycles: dout_valid = 1, dout = captured word j, j = 0..OUT_WORDS-1.
  - No backpressure.
  - After the last word: dout_valid = 0, state -> IDLE, ready = 1.
  - dout holds its last value.
  - Inputs are ignored.
- Counter width is $clog2(RATE_WORDS+1). The counter never exceeds RATE_WORDS.

Optional Feature:
- Macro: KECCAK_IO_PAD_EN.
- Defined: last_block seen in FILL (with or without din_valid in the same cycle) performs hardware padding:
  - Any same-cycle word is stored first; n = resulting count.
  - word[n] ^= 64'h06; word[RATE_WORDS-1] ^= 64'h8000_0000_0000_0000 (when n = RATE_WORDS-1, both XORs apply).
  - Then perm_start pulses and the block enters PERM with a pad flag set.
  - On perm_done with the pad flag set, the block goes directly to SQUEEZE, skipping WAIT_LAST. The pad flag clears.
  - If n == RATE_WORDS, padding is not possible; behave as undefined-free: treat as a normal full block and keep last_block pending to WAIT_LAST.
- Undefined: last_block in FILL is ignored; software must pre-pad full blocks.

Test Plan:
- Reset, start, 21 words din = k+1 (k = 0..20) on consecutive cycles -> cycle after word 21: perm_start = 1 and buffer_full = 1; blk_o word 20 = 21, word 0 = 1.
- perm_done after 24 cycles with rate_i = {4, 3, 2, 1}, then last_block = 1 -> dout 1, 2, 3, 4 on 4 consecutive cycles with dout_valid = 1; then ready = 1 and state IDLE.
- Two-block message: after first perm_done, send 21 more words -> second perm_start; blk_o holds only the new words.
- din_valid held during PERM -> no writes; counter stays 0; blk_o unchanged.
- start asserted after 7 words in FILL -> core_init pulse; 21 more words are needed before perm_start.
- With KECCAK_IO_PAD_EN: 3 words, then last_block -> word3 = 0x06, word20 = 0x8000_0000_0000_0000, perm_start; after perm_done, dout streams without a further last_block.
